// File: rtl/dmem_arbiter_if.sv
// Data-RAM arbiter bus: CPU MEM-stage port, loader/DMA port and single RAM port.
// slave = arbiter side, master = requesters plus RAM.
interface dmem_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_stall;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;

    logic        ldr_req;
    logic        ldr_we;
    logic [31:0] ldr_addr;
    logic [31:0] ldr_wdata;
    logic        ldr_gnt;
    logic        ldr_rvalid;
    logic [31:0] ldr_rdata;

    logic        mem_en;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        addr_err;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_rvalid, cpu_rdata,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output ldr_gnt, ldr_rvalid, ldr_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output addr_err
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_rvalid, cpu_rdata,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  ldr_gnt, ldr_rvalid, ldr_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  addr_err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data-RAM arbiter: CPU priority with loader anti-starvation, same-cycle grant,
// one-cycle read return steered by a registered owner tag; out-of-range accesses return 0.
module dmem_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int ADDR_WORDS = 1068
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starve_q, starve_d;
    logic          rd_cpu_q, rd_cpu_d;
    logic          rd_ldr_q, rd_ldr_d;
    logic          rd_zero_q, rd_zero_d;
    logic          err_q, err_d;

    logic          contested;
    logic          force_ldr;
    logic          cpu_win;
    logic          ldr_win;
    logic          any_win;
    logic          win_we;
    logic [29:0]   win_waddr;
    logic [31:0]   win_wdata;
    logic          oor;
    logic [31:0]   ret_data;

    always_comb begin
        contested = bus.cpu_req & bus.ldr_req;
        force_ldr = (starve_q == SW'(STARVE_MAX));
        cpu_win   = reset & bus.cpu_req & ~(bus.ldr_req & force_ldr);
        ldr_win   = reset & bus.ldr_req & ~cpu_win;
        any_win   = cpu_win | ldr_win;

        win_we    = 1'b0;
        win_waddr = '0;
        win_wdata = '0;
        if (cpu_win) begin
            win_we    = bus.cpu_we;
            win_waddr = bus.cpu_addr[31:2];
            win_wdata = bus.cpu_wdata;
        end else if (ldr_win) begin
            win_we    = bus.ldr_we;
            win_waddr = bus.ldr_addr[31:2];
            win_wdata = bus.ldr_wdata;
        end
        oor = any_win & (win_waddr >= 30'(ADDR_WORDS));
    end

    // Counter only runs while the loader is actually waiting behind the CPU.
    always_comb begin
        starve_d = starve_q;
        if (!reset || !bus.ldr_req || ldr_win) begin
            starve_d = '0;
        end else if (contested && cpu_win) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_comb begin
        rd_cpu_d  = reset & cpu_win & ~bus.cpu_we;
        rd_ldr_d  = reset & ldr_win & ~bus.ldr_we;
        rd_zero_d = reset & oor;
        err_d     = reset & oor;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_q  <= '0;
            rd_cpu_q  <= 1'b0;
            rd_ldr_q  <= 1'b0;
            rd_zero_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            starve_q  <= starve_d;
            rd_cpu_q  <= rd_cpu_d;
            rd_ldr_q  <= rd_ldr_d;
            rd_zero_q <= rd_zero_d;
            err_q     <= err_d;
        end
    end

    assign bus.mem_en    = any_win;
    assign bus.mem_we    = any_win & win_we & ~oor;
    assign bus.mem_addr  = win_waddr;
    assign bus.mem_wdata = win_wdata;

    assign bus.cpu_stall = bus.cpu_req & ~cpu_win;
    assign bus.ldr_gnt   = ldr_win;

    // Gating with reset suppresses a return for a read granted just before reset.
    assign ret_data       = rd_zero_q ? 32'h0 : bus.mem_rdata;
    assign bus.cpu_rvalid = reset & rd_cpu_q;
    assign bus.ldr_rvalid = reset & rd_ldr_q;
    assign bus.cpu_rdata  = bus.cpu_rvalid ? ret_data : 32'h0;
    assign bus.ldr_rdata  = bus.ldr_rvalid ? ret_data : 32'h0;
    assign bus.addr_err   = reset & err_q;
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: contested cycles the CPU may win in a row before the loader is forced a grant.
REQ-002 Parameter ADDR_WORDS, default 1068: number of 32-bit words in the data RAM.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (0 = reset).
REQ-005 cpu_req  input  1  MEM-stage access request.
REQ-006 cpu_we  input  1  CPU write (1) or read (0).
REQ-007 cpu_addr  input  32  CPU byte address (ALU result).
REQ-008 cpu_wdata  input  32  CPU store data.
REQ-009 cpu_stall  output  1  CPU request not granted this cycle; pipeline holds.
REQ-010 cpu_rvalid  output  1  cpu_rdata is valid this cycle.
REQ-011 cpu_rdata  output  32  CPU read data.
REQ-012 ldr_req  input  1  loader/DMA access request.
REQ-013 ldr_we, ldr_addr, ldr_wdata  input  1/32/32  loader write enable, byte address and write data.
REQ-014 ldr_gnt  output  1  loader request accepted this cycle.
REQ-015 ldr_rvalid, ldr_rdata  output  1/32  loader read return.
REQ-016 mem_en, mem_we  output  1/1  RAM enable and write enable.
REQ-017 mem_addr  output  30  RAM word address.
REQ-018 mem_wdata  output  32  RAM write data.
REQ-019 mem_rdata  input  32  RAM read data, registered by the RAM, valid one cycle after a read enable.
REQ-020 addr_err  output  1  registered pulse: the previous granted access was out of range.

Function
REQ-021 The block SHALL arbitrate each cycle combinationally: a sole requester wins; when both request (contested), the CPU wins unless the starvation counter equals STARVE_MAX.
REQ-022 The block SHALL drive the winner's signals onto the RAM port in the same cycle: mem_en=1, mem_we=winner we, mem_addr=winner addr[31:2], mem_wdata=winner wdata.
REQ-023 The block SHALL drive mem_en=0 and mem_we=0 when there is no winner.
REQ-024 cpu_stall SHALL be cpu_req AND NOT cpu_win.
REQ-025 ldr_gnt SHALL be ldr_win.
REQ-026 Starvation counter (width ceil(log2(STARVE_MAX+1))):
  - increments on each contested cycle the CPU wins;
  - clears to 0 on any loader grant;
  - clears to 0 on any cycle with ldr_req=0.
REQ-027 A granted access with word address >= ADDR_WORDS SHALL keep mem_we=0, SHALL still count as a grant, SHALL return read data 0, and SHALL set addr_err=1 for exactly one cycle after the grant.
REQ-028 A granted read SHALL register an owner tag; the following cycle SHALL assert exactly one of cpu_rvalid/ldr_rvalid for one cycle, with that owner's rdata = mem_rdata (or 0 per REQ-027).
REQ-029 The non-owner rdata output SHALL be 0, and both rdata outputs SHALL be 0 whenever the matching rvalid is 0.
REQ-030 Granted writes SHALL produce no rvalid; read-to-read back-to-back grants SHALL sustain one access per cycle.
REQ-031 Simultaneous read return and new grant SHALL be independent: the tag pipeline is one stage deep and is overwritten every cycle.

Reset
REQ-032 While reset=0: no grants, mem_en=0, mem_we=0, cpu_stall=cpu_req, ldr_gnt=0.
REQ-033 While reset=0: starvation counter=0, owner tag cleared, cpu_rvalid=ldr_rvalid=0, rdata outputs=0, addr_err=0.
REQ-034 A read granted in the cycle before reset is asserted SHALL NOT produce an rvalid.
REQ-035 The first cycle after reset deasserts SHALL arbitrate normally.

Verification
REQ-036 CPU-only read, addr 0x10 -> mem_en=1, mem_addr=4, cpu_stall=0; next cycle cpu_rvalid=1, cpu_rdata=RAM[4].
REQ-037 Both request continuously, STARVE_MAX=4 -> CPU granted cycles 0-3, loader granted cycle 4, pattern repeats (4:1).
REQ-038 Loader write 0xDEADBEEF to 0x20 while CPU idle; then CPU read 0x20 -> cpu_rdata=0xDEADBEEF one cycle after its grant.
REQ-039 CPU write to word address 1068 (addr 0x10B0) -> mem_we=0, no stall, addr_err=1 next cycle; RAM unchanged.
REQ-040 CPU read granted, reset=0 asserted on the next edge -> cpu_rvalid stays 0, counter=0; after release a CPU read returns normally.
REQ-041 Loader requests alone for 3 cycles, then CPU joins -> CPU wins the contested cycle (counter was 0), loader stalls one cycle then resumes.
